// File: rtl/fmap_pingpong_ctrl_pkg.sv
// rtl/fmap_pingpong_ctrl_pkg.sv - shared state encoding and geometry constants for the feature-map ping-pong controller
package fmap_ctrl_pkg;

  localparam int FMAP_ADDR_WIDTH = 13;
  localparam int FMAP_BANK_AW    = 12;
  localparam int FMAP_DATA_WIDTH = 144;

  // 3-bit to line up with the current_state width of the sibling controllers
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3
  } fmap_state_e;

endpackage

// File: rtl/fmap_pingpong_ctrl_if.sv
// rtl/fmap_pingpong_ctrl_if.sv - layer control, conv handshake and DRM address bundle
interface fmap_pingpong_ctrl_if import fmap_ctrl_pkg::*; ();

  logic                       layer_start;
  logic [FMAP_BANK_AW-1:0]    rd_len;
  logic [FMAP_BANK_AW-1:0]    wr_len;
  logic                       conv_ready;
  logic                       conv_out_valid;
  logic [FMAP_ADDR_WIDTH-1:0] rd_addr;
  logic                       conv_in_valid;
  logic [FMAP_ADDR_WIDTH-1:0] wr_addr;
  logic                       wr_en;
  logic                       bank_sel;
  logic                       busy;
  logic                       layer_done;
  logic                       wr_overflow;
  logic [31:0]                stall_cycles;

  modport master (
    output layer_start, rd_len, wr_len, conv_ready, conv_out_valid,
    input  rd_addr, conv_in_valid, wr_addr, wr_en, bank_sel, busy,
           layer_done, wr_overflow, stall_cycles
  );

  modport slave (
    input  layer_start, rd_len, wr_len, conv_ready, conv_out_valid,
    output rd_addr, conv_in_valid, wr_addr, wr_en, bank_sel, busy,
           layer_done, wr_overflow, stall_cycles
  );

endinterface

// File: rtl/fmap_pingpong_ctrl_len_counter.sv
// rtl/fmap_pingpong_ctrl_len_counter.sv - enable counter with load-clear, terminal flag against a length, and wrap
module fmap_len_counter import fmap_ctrl_pkg::*; #(
  parameter int WIDTH = FMAP_BANK_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] len,
  output logic [WIDTH-1:0] cnt,
  output logic             term
);

  assign term = (cnt == len);

  // Wrapping at the terminal count keeps a full-bank length from running into the next bank
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fmap_pingpong_ctrl.sv
// rtl/fmap_pingpong_ctrl.sv - ping-pong bank sequencer for the feature-map DRM; FMAP_PERF_CNT_EN enables the stall counter
module fmap_pingpong_ctrl import fmap_ctrl_pkg::*; #(
  parameter int ADDR_WIDTH = FMAP_ADDR_WIDTH,
  parameter int BANK_AW    = FMAP_BANK_AW,
  parameter int RD_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  fmap_pingpong_ctrl_if.slave bus
);

  fmap_state_e         state_q, state_d;
  logic                bank_q;
  logic [BANK_AW-1:0]  rd_len_q, wr_len_q;
  logic [BANK_AW-1:0]  rd_cnt, wr_cnt;
  logic                rd_term, wr_term;
  logic [RD_LATENCY-1:0] pipe_q;
  logic [RD_LATENCY:0]   pipe_ext;
  logic                wr_full_q;
  logic                ovf_q;
  logic                start_ok, rd_issue, wr_win, wr_fire;
  logic [ADDR_WIDTH-1:0] rd_addr_w, wr_addr_w;

  assign start_ok = bus.layer_start && (state_q == IDLE);
  assign rd_issue = (state_q == READ) && bus.conv_ready;
  assign wr_win   = (state_q == READ) || (state_q == DRAIN);
  assign wr_fire  = wr_win && bus.conv_out_valid && !wr_full_q;

  fmap_len_counter #(.WIDTH(BANK_AW)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (rd_issue),
    .len   (rd_len_q),
    .cnt   (rd_cnt),
    .term  (rd_term)
  );

  fmap_len_counter #(.WIDTH(BANK_AW)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (wr_fire),
    .len   (wr_len_q),
    .cnt   (wr_cnt),
    .term  (wr_term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = READ;
      READ:    if (rd_issue && rd_term) state_d = DRAIN;
      DRAIN:   if ((pipe_q == '0) && wr_full_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pipe_ext = {pipe_q, rd_issue};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bank_q    <= 1'b0;
      rd_len_q  <= '0;
      wr_len_q  <= '0;
      pipe_q    <= '0;
      wr_full_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_ext[RD_LATENCY-1:0];
      if (state_q == DONE) bank_q <= ~bank_q;
      if (start_ok) begin
        rd_len_q <= bus.rd_len;
        wr_len_q <= bus.wr_len;
      end
      if (start_ok) begin
        wr_full_q <= 1'b0;
      end else if (wr_fire && wr_term) begin
        wr_full_q <= 1'b1;
      end
      // Any result the write port did not take is lost, whatever the state
      if (start_ok) begin
        ovf_q <= 1'b0;
      end else if (bus.conv_out_valid && !wr_fire) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign rd_addr_w = (state_q == READ) ? {bank_q, rd_cnt} : '0;
  assign wr_addr_w = wr_win ? {~bank_q, wr_cnt} : '0;

  assign bus.rd_addr       = rd_addr_w;
  assign bus.wr_addr       = wr_addr_w;
  assign bus.wr_en         = wr_fire;
  assign bus.conv_in_valid = pipe_q[RD_LATENCY-1];
  assign bus.bank_sel      = bank_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.layer_done    = (state_q == DONE);
  assign bus.wr_overflow   = ovf_q;

`ifdef FMAP_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_q <= '0;
    end else if ((state_q == READ) && !bus.conv_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fmap_pingpong_ctrl.sv
// tb/tb_fmap_pingpong_ctrl.sv - randomized layer sequences checked cycle by cycle against a transaction-level model
module tb_fmap_pingpong_ctrl;
  import fmap_ctrl_pkg::*;

  localparam int RD_LAT = 1;
  localparam int LAYER_BUDGET = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fmap_pingpong_ctrl_if bus();

  fmap_pingpong_ctrl #(.RD_LATENCY(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: layer progress as plain word counts, plus a history of issued reads
  bit     m_active, m_done, m_bank, m_ovf;
  int     m_reads, m_writes, m_rlen, m_wlen;
  longint m_stall;
  bit     hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_bank = 0; m_ovf = 0;
    m_reads = 0; m_writes = 0; m_rlen = 0; m_wlen = 0; m_stall = 0;
    hist.delete();
    for (int i = 0; i < RD_LAT; i++) hist.push_back(1'b0);
  endtask

  task automatic step(input bit r, input bit start, input bit ready, input bit outv,
                      input int rlen, input int wlen, input bit check);
    bit reading, issue, wr_ok, wr_en_e, empty, next_done;
    int exp_rd, exp_wr;
    longint exp_stall;
    rst                = r;
    bus.layer_start    = start;
    bus.rd_len         = 12'(rlen);
    bus.wr_len         = 12'(wlen);
    bus.conv_ready     = ready;
    bus.conv_out_valid = outv;
    @(negedge clk);
    reading = m_active && !m_done && (m_reads <= m_rlen);
    issue   = reading && ready;
    wr_ok   = m_active && !m_done && (m_writes <= m_wlen);
    wr_en_e = wr_ok && outv;
    exp_rd  = reading ? int'(m_bank) * 4096 + m_reads : 0;
    exp_wr  = (m_active && !m_done) ? int'(!m_bank) * 4096 + ((m_writes > m_wlen) ? 0 : m_writes) : 0;
`ifdef FMAP_PERF_CNT_EN
    exp_stall = m_stall;
`else
    exp_stall = 0;
`endif
    if (check) begin
      chk("busy",          32'(bus.busy),          32'(m_active));
      chk("layer_done",    32'(bus.layer_done),    32'(m_done));
      chk("bank_sel",      32'(bus.bank_sel),      32'(m_bank));
      chk("rd_addr",       32'(bus.rd_addr),       32'(exp_rd));
      chk("conv_in_valid", 32'(bus.conv_in_valid), 32'(hist[RD_LAT-1]));
      chk("wr_en",         32'(bus.wr_en),         32'(wr_en_e));
      chk("wr_addr",       32'(bus.wr_addr),       32'(exp_wr));
      chk("wr_overflow",   32'(bus.wr_overflow),   32'(m_ovf));
      chk("stall_cycles",  bus.stall_cycles,       32'(exp_stall));
    end
    if (r) begin
      model_reset();
    end else begin
      empty = 1;
      foreach (hist[i]) if (hist[i]) empty = 0;
      hist.push_front(issue);
      void'(hist.pop_back());
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_done = 0; m_reads = 0; m_writes = 0;
          m_rlen = rlen; m_wlen = wlen; m_ovf = 0; m_stall = 0;
        end else if (outv) begin
          m_ovf = 1;
        end
      end else if (m_done) begin
        m_active = 0; m_done = 0; m_bank = !m_bank;
        if (outv) m_ovf = 1;
      end else begin
        next_done = !reading && empty && (m_writes == m_wlen + 1);
        if (issue) m_reads++;
        if (wr_en_e) m_writes++;
        else if (outv) m_ovf = 1;
        if (reading && !ready && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_done = next_done;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 always ready, 1 toggling starting high, 2 random
  task automatic run_layer(input int rlen, input int wlen, input int ready_mode,
                           input int extra, input int abort_after);
    int cyc = 0;
    int extra_left = extra;
    bit rdy, ov;
    step(0, 1, 0, 0, rlen, wlen, 1);
    while (m_active && cyc < LAYER_BUDGET) begin
      if (abort_after >= 0 && cyc == abort_after) begin
        step(1, 0, 0, 0, 0, 0, 0);
        break;
      end
      case (ready_mode)
        0:       rdy = 1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      ov = 0;
      if (m_writes <= wlen) ov = ($urandom_range(0, 2) == 0);
      else if (extra_left > 0) begin ov = 1; extra_left--; end
      // a second layer_start while busy must be ignored
      step(0, (cyc == 1), rdy, ov, (rlen ^ 5) & 4095, (wlen ^ 3) & 4095, 1);
      cyc++;
    end
    chk("layer_bounded", 32'(cyc < LAYER_BUDGET), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.layer_start = 0; bus.rd_len = '0; bus.wr_len = '0;
    bus.conv_ready = 0; bus.conv_out_valid = 0;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    run_layer(3, 1, 0, 0, -1);
    idle(1);
    chk("bank_after_l1", 32'(bus.bank_sel), 32'd1);
    run_layer(1, 0, 0, 0, -1);
    idle(1);
    chk("bank_after_l2", 32'(bus.bank_sel), 32'd0);

    run_layer(7, 2, 1, 0, -1);
    idle(1);
`ifdef FMAP_PERF_CNT_EN
    chk("stall_toggle", bus.stall_cycles, 32'd7);
`else
    chk("stall_toggle", bus.stall_cycles, 32'd0);
`endif

    run_layer(0, 0, 0, 1, -1);
    idle(2);
    chk("ovf_sticky", 32'(bus.wr_overflow), 32'd1);
    run_layer(2, 0, 2, 0, -1);
    idle(1);

    run_layer(9, 4, 0, 0, 2);
    idle(1);
    run_layer(2, 1, 2, 0, -1);
    idle(1);

    for (int k = 0; k < 5; k++) begin
      run_layer(int'($urandom_range(0, 40)), int'($urandom_range(0, 15)), 2,
                int'($urandom_range(0, 2)), -1);
      idle(int'($urandom_range(1, 3)));
    end

    run_layer(4095, 3, 0, 0, -1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
